// File: rtl/bus_ctrl_if.sv
// Bus controller interface: groups the per-core request/response signals,
// the coherence snoop signals and the single-port RAM signals.
//   slave  : view taken by bus_ctrl (takes core requests, drives the RAM)
//   master : view taken by the cores/RAM side (testbench)
// Per-core vectors are indexed by core number (0 or 1); words are 32 bits.
// ramstate: 0 FREE, 1 BUSY, 2 ACCESS (complete this cycle), 3 ERROR.
interface bus_ctrl_if;
  // core -> controller
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       dREN;
  logic [1:0]       dWEN;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]       cctrans;
  logic [1:0]       ccwrite;
  // controller -> core
  logic [1:0]       iwait;
  logic [1:0]       dwait;
  logic [1:0][31:0] iload;
  logic [1:0][31:0] dload;
  logic [1:0]       ccwait;
  logic [1:0]       ccinv;
  logic [1:0][31:0] ccsnoopaddr;
  // controller <-> RAM
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  logic [1:0]       ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    output iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    input  iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/bus_ctrl.sv
// Two-core coherent bus controller in front of a single-port RAM.
// Arbitrates data requests (priority) and instruction fetches between two cores,
// runs snoop / invalidate / cache-to-cache writeback sequences and RAM loads/stores.
// Ports:
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset
//   bus  : bus_ctrl_if.slave (core requests, snoop signals, RAM strobes)
module bus_ctrl (
  input logic        CLK,
  input logic        nRST,
  bus_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    StIdle, StInv, StSnoop, StLd1, StLd2, StCcwb1, StCcwb2, StWb, StIf
  } state_t;

  localparam logic [1:0] RamAccess = 2'd2;

  state_t      state_q;
  logic        req_q;     // granted core
  logic [31:0] addr_q;    // daddr of the granted core, used as snoop address
  logic        ccw_q;     // ccwrite of the granted core at grant time
  logic        d_rr_q;    // data round-robin pointer
  logic        i_rr_q;    // instruction round-robin pointer

  logic        other;
  logic        ram_access;
  logic [1:0]  dreq;
  logic [1:0]  ireq;
  logic        d_pick;
  logic        i_pick;

  assign other      = ~req_q;
  assign ram_access = (bus.ramstate == RamAccess);

  // A bare cctrans&ccwrite (upgrade to modified) is a data request too.
  always_comb begin
    dreq   = bus.dREN | bus.dWEN | (bus.cctrans & bus.ccwrite);
    ireq   = bus.iREN;
    d_pick = (dreq == 2'b11) ? d_rr_q : dreq[1];
    i_pick = (ireq == 2'b11) ? i_rr_q : ireq[1];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      addr_q  <= '0;
      ccw_q   <= 1'b0;
      d_rr_q  <= 1'b0;
      i_rr_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|dreq) begin
            req_q  <= d_pick;
            addr_q <= bus.daddr[d_pick];
            ccw_q  <= bus.ccwrite[d_pick];
            d_rr_q <= ~d_rr_q;
            if (bus.dREN[d_pick]) begin
              state_q <= bus.cctrans[d_pick] ? StSnoop : StLd1;
            end else if (bus.dWEN[d_pick]) begin
              state_q <= StWb;
            end else begin
              state_q <= StInv;
            end
          end else if (|ireq) begin
            req_q   <= i_pick;
            i_rr_q  <= ~i_rr_q;
            state_q <= StIf;
          end
        end
        StInv:   state_q <= StIdle;
        // The snooped core answers within the snoop cycle: dirty -> it supplies the line.
        StSnoop: state_q <= (bus.cctrans[other] & bus.ccwrite[other]) ? StCcwb1 : StLd1;
        StLd1:   if (ram_access) state_q <= StLd2;
        StLd2:   if (ram_access) state_q <= StIdle;
        StCcwb1: if (ram_access) state_q <= StCcwb2;
        StCcwb2: if (ram_access) state_q <= StIdle;
        // Stay while the core keeps streaming writes.
        StWb:    if (!ram_access && !bus.dWEN[req_q]) state_q <= StIdle;
        StIf:    if (ram_access) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode from the state register and ramstate so a core sees its wait drop
  // in the same cycle the RAM reports ACCESS; reset forces IDLE and thus the defaults.
  always_comb begin
    bus.iwait       = 2'b11;
    bus.dwait       = 2'b11;
    bus.iload       = '0;
    bus.dload       = '0;
    bus.ccwait      = 2'b00;
    bus.ccinv       = 2'b00;
    bus.ccsnoopaddr = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;
    unique case (state_q)
      StInv: begin
        bus.ccwait[other]      = 1'b1;
        bus.ccinv[other]       = 1'b1;
        bus.ccsnoopaddr[other] = addr_q;
      end
      StSnoop: begin
        bus.ccwait[other]      = 1'b1;
        bus.ccinv[other]       = ccw_q;
        bus.ccsnoopaddr[other] = addr_q;
      end
      StLd1, StLd2: begin
        bus.ramREN         = 1'b1;
        bus.ramaddr        = bus.daddr[req_q];
        bus.dload[req_q]   = bus.ramload;
        if (ram_access) bus.dwait[req_q] = 1'b0;
      end
      // Dirty line goes to RAM and straight to the requester in one transfer.
      StCcwb1, StCcwb2: begin
        bus.ccwait[other]  = 1'b1;
        bus.ramWEN         = 1'b1;
        bus.ramaddr        = bus.daddr[other];
        bus.ramstore       = bus.dstore[other];
        bus.dload[req_q]   = bus.dstore[other];
        if (ram_access) begin
          bus.dwait[other] = 1'b0;
          bus.dwait[req_q] = 1'b0;
        end
      end
      StWb: begin
        bus.ramWEN         = 1'b1;
        bus.ramaddr        = bus.daddr[req_q];
        bus.ramstore       = bus.dstore[req_q];
        if (ram_access) bus.dwait[req_q] = 1'b0;
      end
      StIf: begin
        bus.ramREN         = 1'b1;
        bus.ramaddr        = bus.iaddr[req_q];
        bus.iload[req_q]   = bus.ramload;
        if (ram_access) bus.iwait[req_q] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_ctrl.sv
// Self-checking bench for bus_ctrl: RAM model with programmable latency/error,
// per-core scoreboard queues for load data and a queue of expected RAM writes.
module tb_bus_ctrl;

  localparam logic [1:0] Free = 2'd0, Busy = 2'd1, Access = 2'd2, Error = 2'd3;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  bus_ctrl_if bif ();

  bus_ctrl dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bif)
  );

  // RAM model: ACCESS after ram_lat BUSY cycles of a held strobe, ERROR while ram_err.
  int ram_lat;
  bit ram_err;
  int ram_cnt;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h200) return 32'h1234_5678;
    return {a[15:0], ~a[15:0]};
  endfunction

  always_comb begin
    if (!(bif.ramREN || bif.ramWEN)) bif.ramstate = Free;
    else if (ram_err)                bif.ramstate = Error;
    else if (ram_cnt >= ram_lat)     bif.ramstate = Access;
    else                             bif.ramstate = Busy;
    bif.ramload = (bif.ramstate == Access) ? mem_rd(bif.ramaddr) : 32'hBAD0_BAD0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) ram_cnt <= 0;
    else if ((bif.ramREN || bif.ramWEN) && bif.ramstate != Access) ram_cnt <= ram_cnt + 1;
    else ram_cnt <= 0;
  end

  // Scoreboard: {check_data, data} per completion, {addr, data} per RAM write.
  logic [32:0] dq0[$], dq1[$], iq0[$], iq1[$];
  logic [63:0] wq[$];

  int n_total = 0;
  int n_pass  = 0;
  int n_dacc[2], n_iacc[2], n_ccw[2], n_cci[2];
  int n_wacc, n_racc, n_busy;
  logic [31:0] snp[2];
  bit ok;

  task automatic clear_cnt();
    for (int i = 0; i < 2; i++) begin
      n_dacc[i] = 0; n_iacc[i] = 0; n_ccw[i] = 0; n_cci[i] = 0; snp[i] = '0;
    end
    n_wacc = 0; n_racc = 0; n_busy = 0;
  endtask

  task automatic drive_zero();
    bif.iREN = '0; bif.dREN = '0; bif.dWEN = '0; bif.cctrans = '0; bif.ccwrite = '0;
    bif.iaddr = '0; bif.daddr = '0; bif.dstore = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Advance cycle by cycle, scoring every completion and RAM write, until core's
  // n-th data (is_i=0) or instruction (is_i=1) completion or the budget runs out.
  task automatic run(input bit is_i, input int core, input int n, input int budget,
                     output bit done);
    logic [32:0] e;
    logic [63:0] w;
    bit empty;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge CLK);
      if (bif.ramREN || bif.ramWEN) begin
        n_total++;
        if (bif.ramREN && bif.ramWEN) $display("FAIL strobe_excl: ramREN=1 ramWEN=1, want one");
        else n_pass++;
      end
      if (bif.ramstate == Busy) n_busy++;
      if (bif.ramREN && bif.ramstate == Access) n_racc++;
      if (bif.ramWEN && bif.ramstate == Access) begin
        n_wacc++;
        n_total++;
        if (wq.size() == 0) begin
          $display("FAIL ram_write: unexpected addr=%h data=%h", bif.ramaddr, bif.ramstore);
        end else begin
          w = wq.pop_front();
          if ({bif.ramaddr, bif.ramstore} !== w)
            $display("FAIL ram_write: got %h/%h want %h/%h", bif.ramaddr, bif.ramstore,
                     w[63:32], w[31:0]);
          else n_pass++;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (bif.ccwait[i]) begin
          if (n_ccw[i] == 0) snp[i] = bif.ccsnoopaddr[i];
          n_ccw[i]++;
        end
        if (bif.ccinv[i]) n_cci[i]++;
        if (bif.dwait[i] == 1'b0) begin
          n_dacc[i]++;
          n_total++;
          empty = (i == 0) ? (dq0.size() == 0) : (dq1.size() == 0);
          if (empty) begin
            $display("FAIL dcomplete%0d: unexpected completion, dload=%h", i, bif.dload[i]);
          end else begin
            if (i == 0) e = dq0.pop_front();
            else        e = dq1.pop_front();
            if (e[32] && bif.dload[i] !== e[31:0])
              $display("FAIL dload%0d: got %h want %h", i, bif.dload[i], e[31:0]);
            else n_pass++;
          end
        end
        if (bif.iwait[i] == 1'b0) begin
          n_iacc[i]++;
          n_total++;
          empty = (i == 0) ? (iq0.size() == 0) : (iq1.size() == 0);
          if (empty) begin
            $display("FAIL icomplete%0d: unexpected completion, iload=%h", i, bif.iload[i]);
          end else begin
            if (i == 0) e = iq0.pop_front();
            else        e = iq1.pop_front();
            if (bif.iload[i] !== e[31:0])
              $display("FAIL iload%0d: got %h want %h", i, bif.iload[i], e[31:0]);
            else n_pass++;
          end
        end
      end
      if (is_i ? (n_iacc[core] >= n) : (n_dacc[core] >= n)) done = 1'b1;
    end
  endtask

  task automatic test_reset();
    drive_zero();
    ram_lat = 0;
    ram_err = 1'b0;
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK);
    n_total++; if (bif.iwait !== 2'b11) $display("FAIL rst_iwait: got %b want 11", bif.iwait); else n_pass++;
    n_total++; if (bif.dwait !== 2'b11) $display("FAIL rst_dwait: got %b want 11", bif.dwait); else n_pass++;
    n_total++; if ({bif.ramREN, bif.ramWEN} !== 2'b00)
      $display("FAIL rst_strobes: got %b%b want 00", bif.ramREN, bif.ramWEN); else n_pass++;
    n_total++; if ({bif.ccwait, bif.ccinv} !== 4'b0)
      $display("FAIL rst_cc: got %b/%b want 00/00", bif.ccwait, bif.ccinv); else n_pass++;
    n_total++; if ({bif.ramaddr, bif.ramstore} !== 64'h0)
      $display("FAIL rst_rambus: got %h/%h want 0/0", bif.ramaddr, bif.ramstore); else n_pass++;
    n_total++; if ({bif.dload, bif.iload, bif.ccsnoopaddr} !== '0)
      $display("FAIL rst_loads: got nonzero load/snoop bus, want 0"); else n_pass++;
  endtask

  // Both cores snoop-read 0x40 together: core 0 wins, core 1 follows.
  task automatic test_snoop_tie();
    ram_lat = 1;
    clear_cnt();
    tick();
    bif.dREN = 2'b11; bif.cctrans = 2'b11; bif.ccwrite = 2'b00;
    bif.daddr[0] = 32'h40; bif.daddr[1] = 32'h40;
    repeat (2) dq0.push_back({1'b1, mem_rd(32'h40)});
    repeat (2) dq1.push_back({1'b1, mem_rd(32'h40)});
    run(1'b0, 0, 2, 40, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL tie_core0_done: got %b want 1", ok); else n_pass++;
    n_total++; if (n_ccw[1] !== 1) $display("FAIL tie_ccwait1: got %0d cycles want 1", n_ccw[1]); else n_pass++;
    n_total++; if (snp[1] !== 32'h40) $display("FAIL tie_snoopaddr1: got %h want 40", snp[1]); else n_pass++;
    n_total++; if (n_cci[1] !== 0) $display("FAIL tie_ccinv1: got %0d want 0", n_cci[1]); else n_pass++;
    n_total++; if (n_dacc[1] !== 0) $display("FAIL tie_core1_held: got %0d want 0", n_dacc[1]); else n_pass++;
    n_total++; if (n_racc !== 2) $display("FAIL tie_ram_reads: got %0d want 2", n_racc); else n_pass++;
    tick();
    bif.dREN[0] = 1'b0; bif.cctrans[0] = 1'b0;
    clear_cnt();
    run(1'b0, 1, 2, 40, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL tie_core1_done: got %b want 1", ok); else n_pass++;
    n_total++; if (n_ccw[0] !== 1) $display("FAIL tie_ccwait0: got %0d cycles want 1", n_ccw[0]); else n_pass++;
    n_total++; if (snp[0] !== 32'h40) $display("FAIL tie_snoopaddr0: got %h want 40", snp[0]); else n_pass++;
    tick();
    drive_zero();
  endtask

  task automatic test_inv();
    tick();
    bif.cctrans = 2'b10; bif.ccwrite = 2'b10; bif.daddr[1] = 32'h80;
    @(negedge CLK);
    n_total++; if (bif.ccwait !== 2'b00) $display("FAIL inv_idle_ccwait: got %b want 00", bif.ccwait); else n_pass++;
    tick();
    drive_zero();
    @(negedge CLK);
    n_total++; if (bif.ccwait !== 2'b01) $display("FAIL inv_ccwait: got %b want 01", bif.ccwait); else n_pass++;
    n_total++; if (bif.ccinv !== 2'b01) $display("FAIL inv_ccinv: got %b want 01", bif.ccinv); else n_pass++;
    n_total++; if (bif.ccsnoopaddr[0] !== 32'h80)
      $display("FAIL inv_snoopaddr: got %h want 80", bif.ccsnoopaddr[0]); else n_pass++;
    n_total++; if ({bif.dwait, bif.ramREN, bif.ramWEN} !== 4'b1100)
      $display("FAIL inv_quiet: got dwait=%b ren=%b wen=%b", bif.dwait, bif.ramREN, bif.ramWEN); else n_pass++;
    tick();
    @(negedge CLK);
    n_total++; if ({bif.ccwait, bif.ccinv} !== 4'b0)
      $display("FAIL inv_back_idle: got %b/%b want 00/00", bif.ccwait, bif.ccinv); else n_pass++;
  endtask

  // Core 0 read-miss, core 1 holds the line dirty and supplies it.
  task automatic test_ccwb();
    ram_lat = 0;
    clear_cnt();
    tick();
    bif.dREN = 2'b01; bif.cctrans = 2'b01; bif.daddr[0] = 32'h100;
    tick();
    @(negedge CLK);
    n_total++; if (bif.ccwait !== 2'b10) $display("FAIL ccwb_snoop: got %b want 10", bif.ccwait); else n_pass++;
    n_total++; if (bif.ccsnoopaddr[1] !== 32'h100)
      $display("FAIL ccwb_snoopaddr: got %h want 100", bif.ccsnoopaddr[1]); else n_pass++;
    bif.cctrans[1] = 1'b1; bif.ccwrite[1] = 1'b1;
    bif.daddr[1] = 32'h100; bif.dstore[1] = 32'hDEAD_BEEF;
    repeat (2) begin
      dq0.push_back({1'b1, 32'hDEAD_BEEF});
      dq1.push_back({1'b0, 32'h0});
      wq.push_back({32'h100, 32'hDEAD_BEEF});
    end
    run(1'b0, 0, 2, 20, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL ccwb_done: got %b want 1", ok); else n_pass++;
    n_total++; if (n_dacc[1] !== 2) $display("FAIL ccwb_dwait1: got %0d want 2", n_dacc[1]); else n_pass++;
    n_total++; if (n_wacc !== 2) $display("FAIL ccwb_writes: got %0d want 2", n_wacc); else n_pass++;
    n_total++; if (n_ccw[1] !== 2) $display("FAIL ccwb_ccwait: got %0d want 2", n_ccw[1]); else n_pass++;
    tick();
    drive_zero();
  endtask

  task automatic test_if_busy();
    ram_lat = 3;
    clear_cnt();
    tick();
    bif.iREN = 2'b10; bif.iaddr[1] = 32'h200;
    iq1.push_back({1'b1, 32'h1234_5678});
    run(1'b1, 1, 1, 20, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL if_done: got %b want 1", ok); else n_pass++;
    n_total++; if (n_busy !== 3) $display("FAIL if_busy_cycles: got %0d want 3", n_busy); else n_pass++;
    n_total++; if (n_iacc[0] !== 0) $display("FAIL if_core0_quiet: got %0d want 0", n_iacc[0]); else n_pass++;
    tick();
    drive_zero();
  endtask

  // Reset in LD2, then check both pointers restart from core 0.
  task automatic test_reset_mid();
    ram_lat = 2;
    clear_cnt();
    tick();
    bif.dREN = 2'b10; bif.cctrans = 2'b10; bif.daddr[1] = 32'h500;
    dq1.push_back({1'b1, mem_rd(32'h500)});
    run(1'b0, 1, 1, 20, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL rmid_ld1: got %b want 1", ok); else n_pass++;
    @(posedge CLK);
    #2;
    n_total++; if (bif.ramREN !== 1'b1) $display("FAIL rmid_in_ld2: got %b want 1", bif.ramREN); else n_pass++;
    nRST = 1'b0;
    #1;
    n_total++; if (bif.ramREN !== 1'b0) $display("FAIL rmid_ren: got %b want 0", bif.ramREN); else n_pass++;
    n_total++; if ({bif.dwait, bif.iwait} !== 4'b1111)
      $display("FAIL rmid_waits: got %b/%b want 11/11", bif.dwait, bif.iwait); else n_pass++;
    drive_zero();
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    n_total++; if (bif.ramREN !== 1'b0) $display("FAIL rmid_idle: got %b want 0", bif.ramREN); else n_pass++;
    ram_lat = 0;
    tick();
    bif.dREN = 2'b11; bif.cctrans = 2'b11;
    bif.daddr[0] = 32'h600; bif.daddr[1] = 32'h700;
    repeat (2) dq0.push_back({1'b1, mem_rd(32'h600)});
    clear_cnt();
    run(1'b0, 0, 2, 20, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL rmid_d0_first: got %b want 1", ok); else n_pass++;
    n_total++; if (n_dacc[1] !== 0) $display("FAIL rmid_d_ptr: core1 got %0d want 0", n_dacc[1]); else n_pass++;
    tick();
    bif.dREN[0] = 1'b0; bif.cctrans[0] = 1'b0;
    repeat (2) dq1.push_back({1'b1, mem_rd(32'h700)});
    run(1'b0, 1, 2, 20, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL rmid_d1_next: got %b want 1", ok); else n_pass++;
    tick();
    drive_zero();
    bif.iREN = 2'b11; bif.iaddr[0] = 32'h800; bif.iaddr[1] = 32'h900;
    iq0.push_back({1'b1, mem_rd(32'h800)});
    clear_cnt();
    run(1'b1, 0, 1, 20, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL rmid_i0_first: got %b want 1", ok); else n_pass++;
    n_total++; if (n_iacc[1] !== 0) $display("FAIL rmid_i_ptr: core1 got %0d want 0", n_iacc[1]); else n_pass++;
    tick();
    bif.iREN[0] = 1'b0;
    iq1.push_back({1'b1, mem_rd(32'h900)});
    run(1'b1, 1, 1, 20, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL rmid_i1_next: got %b want 1", ok); else n_pass++;
    tick();
    drive_zero();
  endtask

  // Two back-to-back stores in one WB burst.
  task automatic test_wb();
    ram_lat = 1;
    clear_cnt();
    tick();
    bif.dWEN = 2'b01; bif.daddr[0] = 32'h400; bif.dstore[0] = 32'h1111_1111;
    dq0.push_back({1'b0, 32'h0});
    wq.push_back({32'h400, 32'h1111_1111});
    run(1'b0, 0, 1, 20, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL wb_first: got %b want 1", ok); else n_pass++;
    tick();
    bif.daddr[0] = 32'h404; bif.dstore[0] = 32'h2222_2222;
    dq0.push_back({1'b0, 32'h0});
    wq.push_back({32'h404, 32'h2222_2222});
    run(1'b0, 0, 2, 20, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL wb_second: got %b want 1", ok); else n_pass++;
    tick();
    bif.dWEN = 2'b00;
    @(negedge CLK);
    n_total++; if (bif.ramWEN !== 1'b1) $display("FAIL wb_hold: got %b want 1", bif.ramWEN); else n_pass++;
    tick();
    @(negedge CLK);
    n_total++; if (bif.ramWEN !== 1'b0) $display("FAIL wb_exit: got %b want 0", bif.ramWEN); else n_pass++;
    n_total++; if (n_wacc !== 2) $display("FAIL wb_writes: got %0d want 2", n_wacc); else n_pass++;
    drive_zero();
  endtask

  task automatic test_error_hold();
    ram_err = 1'b1;
    clear_cnt();
    tick();
    bif.iREN = 2'b01; bif.iaddr[0] = 32'h300;
    run(1'b1, 0, 1, 8, ok);
    n_total++; if (ok !== 1'b0) $display("FAIL err_no_complete: got %b want 0", ok); else n_pass++;
    n_total++; if ({bif.ramREN, bif.iwait} !== 3'b111)
      $display("FAIL err_hold: got ren=%b iwait=%b want 1/11", bif.ramREN, bif.iwait); else n_pass++;
    ram_err = 1'b0;
    ram_lat = 0;
    iq0.push_back({1'b1, mem_rd(32'h300)});
    run(1'b1, 0, 1, 5, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL err_recover: got %b want 1", ok); else n_pass++;
    tick();
    drive_zero();
  endtask

  initial begin
    nRST = 1'b0;
    clear_cnt();
    test_reset();
    test_snoop_tie();
    test_inv();
    test_ccwb();
    test_if_busy();
    test_reset_mid();
    test_wb();
    test_error_hold();
    n_total++;
    if (dq0.size() + dq1.size() + iq0.size() + iq1.size() + wq.size() != 0)
      $display("FAIL sb_drain: got %0d entries left want 0",
               dq0.size() + dq1.size() + iq0.size() + iq1.size() + wq.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
